wr_ctrl_wbuf: RTL and testbench
===============================

WR_CTRL_WBUF -- requirements
Module: wr_ctrl_wbuf

Interface
REQ-001 addr_width, 32, byte address width.
REQ-002 data_width, 32, data word width; multiple of 8; BW=$clog2(data_width/8).
REQ-003 list_depth, 4, number of cache lines; TW=$clog2(list_depth).
REQ-004 list_width, 32, words per line; WW=$clog2(list_width); OFF=BW+WW.
REQ-005 wbuf_depth, 4, write-buffer entries; power of 2, >=2.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 acc_wr_valid  in  1  write request valid.
REQ-009 acc_wr_ready  out  1  write request accepted when high with valid.
REQ-010 acc_wr_addr  in  addr_width  byte address.
REQ-011 acc_wr_data  in  data_width  write data.
REQ-012 acc_wr_strb  in  data_width/8  byte enables.
REQ-013 acc_req  out  1  line-list request.
REQ-014 acc_gnt  in  1  line-list grant; acc_status, return_tag and return_index are valid in the grant cycle.
REQ-015 acc_cmd  out  2  00 lookup, 10 allocate, 11 mark dirty.
REQ-016 acc_index  out  addr_width  line address of the head entry (low OFF bits zero).
REQ-017 acc_tag  out  TW  tag for mark dirty.
REQ-018 acc_status  in  3  001 hit, 000 clean miss, 010 dirty miss, 100 line busy.
REQ-019 return_tag  in  TW  hit or allocated line slot.
REQ-020 return_index  in  addr_width  victim line address (allocate only).
REQ-021 fetch_req  out  1  fetch engine request.
REQ-022 fetch_gnt  in  1  fetch accepted.
REQ-023 fetch_cmd  out  2  00 writeback, 01 refill.
REQ-024 fetch_addr  out  addr_width  line address.
REQ-025 fetch_tag  out  TW  line slot.
REQ-026 fetch_done  in  1  one-cycle completion pulse.
REQ-027 mem_wen / mem_wready  out / in  1 / 1  data-RAM write handshake.
REQ-028 mem_waddr, mem_wdata, mem_wstrb  out  TW+WW, data_width, data_width/8  RAM word address {tag, word index}, data, byte enables.

Function
REQ-029 FIFO of wbuf_depth entries {addr, data, strb}; acc_wr_ready=!full; no same-cycle pass-through when full; head popped on the MEM_WR handshake; writes retire strictly in acceptance order.
REQ-030 Word index = addr[OFF-1:BW]; line address = addr with addr[OFF-1:0] cleared.
REQ-031 FSM states: IDLE, LOOKUP, ALLOC, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, MEM_WR, UPDATE; IDLE->LOOKUP one cycle after the FIFO becomes non-empty.
REQ-032 LOOKUP: acc_req=1, cmd 00; on grant: 001 -> latch return_tag, go MEM_WR; 000 or 010 -> ALLOC; 100 -> stay and reissue next cycle.
REQ-033 ALLOC: acc_req=1, cmd 10; on grant latch return_tag and return_index; 010 -> WB_REQ, else -> RF_REQ.
REQ-034 WB_REQ: fetch_req=1, cmd 00, addr=latched victim index; grant -> WB_WAIT; fetch_done -> RF_REQ.
REQ-035 RF_REQ: fetch_req=1, cmd 01, addr=head line address; grant -> RF_WAIT; fetch_done -> MEM_WR; fetch_tag=latched tag in all fetch states.
REQ-036 MEM_WR: mem_wen=1 with head data/strb; on mem_wready pop -> UPDATE.
REQ-037 UPDATE: acc_req=1, cmd 11, acc_tag=latched tag; on grant -> LOOKUP if FIFO non-empty (including a same-cycle push), else IDLE.
REQ-038 Request outputs are held stable until granted; acc_gnt is ignored while acc_req=0; fetch_done is ignored outside WB_WAIT/RF_WAIT.
REQ-039 Hit latency with immediate grants is 3 cycles from LOOKUP to UPDATE grant.

Reset
REQ-040 Reset gives IDLE, an empty FIFO, zero pointers and tags, all outputs 0 except acc_wr_ready=1; mid-operation reset discards buffered writes and abandons the outstanding fetch.

Configuration
REQ-041 WR_CTRL_MERGE_EN defined: a write matching the tail entry's word address (tail not head) merges into the tail. Merge replaces strobed bytes and ORs strb; no new entry is allocated; acc_wr_ready=1 for a merging write even when full.
REQ-042 WR_CTRL_MERGE_EN undefined: every accepted write allocates a new entry.

Verification
REQ-043 Hit: write 0x104 data 0xDEADBEEF strb F, status 001, tag 2 -> mem_waddr 7'h41, then acc_cmd 11 with acc_tag 2.
REQ-044 Dirty miss to 0x100: status 010, return_index 0x300, tag 1 -> fetch 00/0x300/1, fetch 01/0x100/1, mem write to 7'h20, then cmd 11.
REQ-045 acc_gnt held low while 4 writes are pushed -> acc_wr_ready=0; a 5th write is accepted only after the first mem_wen&&mem_wready.
REQ-046 Status 100 three times then 001 -> four lookup grants and exactly one mem write.
REQ-047 Merge: head at 0x100 stalled; writes to 0x200 with strb 3/data 0x1111, then strb C/data 0x22220000 -> macro on: one mem write, data 0x22221111, strb F; macro off: two mem writes.
REQ-048 rst_n low during RF_WAIT -> next cycle IDLE, fetch_req=0, acc_wr_ready=1, no mem write.

Source files
------------

// File: rtl/wr_ctrl_wbuf.sv
// Write controller: in-order write buffer feeding a line-list / fetch-engine / data-RAM write path.
// Define WR_CTRL_MERGE_EN to merge a write into a matching non-head tail entry.
module wr_ctrl_wbuf #(
  parameter int unsigned addr_width = 32,
  parameter int unsigned data_width = 32,
  parameter int unsigned list_depth = 4,
  parameter int unsigned list_width = 32,
  parameter int unsigned wbuf_depth = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   acc_wr_valid,
  output logic                                                   acc_wr_ready,
  input  logic [addr_width-1:0]                                  acc_wr_addr,
  input  logic [data_width-1:0]                                  acc_wr_data,
  input  logic [data_width/8-1:0]                                acc_wr_strb,
  output logic                                                   acc_req,
  input  logic                                                   acc_gnt,
  output logic [1:0]                                             acc_cmd,
  output logic [addr_width-1:0]                                  acc_index,
  output logic [$clog2(list_depth)-1:0]                          acc_tag,
  input  logic [2:0]                                             acc_status,
  input  logic [$clog2(list_depth)-1:0]                          return_tag,
  input  logic [addr_width-1:0]                                  return_index,
  output logic                                                   fetch_req,
  input  logic                                                   fetch_gnt,
  output logic [1:0]                                             fetch_cmd,
  output logic [addr_width-1:0]                                  fetch_addr,
  output logic [$clog2(list_depth)-1:0]                          fetch_tag,
  input  logic                                                   fetch_done,
  output logic                                                   mem_wen,
  input  logic                                                   mem_wready,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0]       mem_waddr,
  output logic [data_width-1:0]                                  mem_wdata,
  output logic [data_width/8-1:0]                                mem_wstrb
);

  localparam int unsigned SW   = data_width / 8;
  localparam int unsigned BW   = $clog2(SW);
  localparam int unsigned TW   = $clog2(list_depth);
  localparam int unsigned WW   = $clog2(list_width);
  localparam int unsigned OFF  = BW + WW;
  localparam int unsigned PW   = $clog2(wbuf_depth);
  localparam int unsigned PtrW = PW + 1;
  localparam int unsigned AW   = addr_width - BW;

  typedef enum logic [3:0] {
    StIdle, StLookup, StAlloc, StWbReq, StWbWait, StRfReq, StRfWait, StMemWr, StUpdate
  } state_e;

  state_e state_q, state_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic [addr_width-1:0] victim_q, victim_d;

  // Entries keep the word address only; byte offset within a word is never needed.
  logic [AW-1:0]         wa_q   [wbuf_depth];
  logic [AW-1:0]         wa_d   [wbuf_depth];
  logic [data_width-1:0] data_q [wbuf_depth];
  logic [data_width-1:0] data_d [wbuf_depth];
  logic [SW-1:0]         strb_q [wbuf_depth];
  logic [SW-1:0]         strb_d [wbuf_depth];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [PtrW-1:0] count;
  logic            full, empty, push, pop, merge;
  logic [PW-1:0]   wr_idx, head_idx;
  logic [AW-1:0]   head_wa;
  logic [addr_width-1:0] head_line;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^acc_wr_addr[BW-1:0];

  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == PtrW'(wbuf_depth));
  assign empty    = (count == '0);
  assign wr_idx   = wr_ptr_q[PW-1:0];
  assign head_idx = rd_ptr_q[PW-1:0];
  assign head_wa  = wa_q[head_idx];
  assign head_line = {head_wa[AW-1:WW], {OFF{1'b0}}};

`ifdef WR_CTRL_MERGE_EN
  logic [PW-1:0] tail_idx;
  assign tail_idx = wr_idx - PW'(1);
  // Tail must differ from head so the entry being written to RAM is never modified.
  assign merge = acc_wr_valid && (count >= PtrW'(2)) &&
                 (wa_q[tail_idx] == acc_wr_addr[addr_width-1:BW]);
`else
  assign merge = 1'b0;
`endif

  assign acc_wr_ready = !full || merge;
  assign push         = acc_wr_valid && !full && !merge;
  assign pop          = (state_q == StMemWr) && mem_wready;

  always_comb begin
    wa_d     = wa_q;
    data_d   = data_q;
    strb_d   = strb_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wa_d[wr_idx]   = acc_wr_addr[addr_width-1:BW];
      data_d[wr_idx] = acc_wr_data;
      strb_d[wr_idx] = acc_wr_strb;
      wr_ptr_d       = wr_ptr_q + PtrW'(1);
    end
`ifdef WR_CTRL_MERGE_EN
    if (merge) begin
      for (int i = 0; i < SW; i++) begin
        if (acc_wr_strb[i]) data_d[tail_idx][8*i +: 8] = acc_wr_data[8*i +: 8];
      end
      strb_d[tail_idx] = strb_q[tail_idx] | acc_wr_strb;
    end
`endif
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < wbuf_depth; i++) begin
        wa_q[i]   <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wa_q     <= wa_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      tag_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    victim_d = victim_q;
    unique case (state_q)
      StIdle:   if (!empty) state_d = StLookup;
      StLookup: begin
        if (acc_gnt) begin
          case (acc_status)
            3'b001: begin
              tag_d   = return_tag;
              state_d = StMemWr;
            end
            3'b000, 3'b010: state_d = StAlloc;
            default: ;  // line busy: reissue the lookup
          endcase
        end
      end
      StAlloc: begin
        if (acc_gnt) begin
          tag_d    = return_tag;
          victim_d = return_index;
          state_d  = (acc_status == 3'b010) ? StWbReq : StRfReq;
        end
      end
      StWbReq:  if (fetch_gnt)  state_d = StWbWait;
      StWbWait: if (fetch_done) state_d = StRfReq;
      StRfReq:  if (fetch_gnt)  state_d = StRfWait;
      StRfWait: if (fetch_done) state_d = StMemWr;
      StMemWr:  if (mem_wready) state_d = StUpdate;
      StUpdate: if (acc_gnt)    state_d = (!empty || push) ? StLookup : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_req    = 1'b0;
    acc_cmd    = 2'b00;
    acc_tag    = '0;
    fetch_req  = 1'b0;
    fetch_cmd  = 2'b00;
    fetch_addr = '0;
    fetch_tag  = '0;
    mem_wen    = 1'b0;
    unique case (state_q)
      StLookup: acc_req = 1'b1;
      StAlloc: begin
        acc_req = 1'b1;
        acc_cmd = 2'b10;
      end
      StWbReq, StWbWait: begin
        fetch_req  = (state_q == StWbReq);
        fetch_addr = victim_q;
        fetch_tag  = tag_q;
      end
      StRfReq, StRfWait: begin
        fetch_req  = (state_q == StRfReq);
        fetch_cmd  = 2'b01;
        fetch_addr = head_line;
        fetch_tag  = tag_q;
      end
      StMemWr: mem_wen = 1'b1;
      StUpdate: begin
        acc_req = 1'b1;
        acc_cmd = 2'b11;
        acc_tag = tag_q;
      end
      default: ;
    endcase
  end

  assign acc_index = head_line;
  assign mem_waddr = {tag_q, head_wa[WW-1:0]};
  assign mem_wdata = data_q[head_idx];
  assign mem_wstrb = strb_q[head_idx];

endmodule

// File: tb/tb_wr_ctrl_wbuf.sv
// Directed testbench for wr_ctrl_wbuf (default 32-bit / 4-line / 32-word / 4-entry configuration).
module tb_wr_ctrl_wbuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_wr_valid = 1'b0;
  logic        acc_wr_ready;
  logic [31:0] acc_wr_addr = '0;
  logic [31:0] acc_wr_data = '0;
  logic [3:0]  acc_wr_strb = '0;
  logic        acc_req;
  logic        acc_gnt = 1'b0;
  logic [1:0]  acc_cmd;
  logic [31:0] acc_index;
  logic [1:0]  acc_tag;
  logic [2:0]  acc_status = '0;
  logic [1:0]  return_tag = '0;
  logic [31:0] return_index = '0;
  logic        fetch_req;
  logic        fetch_gnt = 1'b0;
  logic [1:0]  fetch_cmd;
  logic [31:0] fetch_addr;
  logic [1:0]  fetch_tag;
  logic        fetch_done = 1'b0;
  logic        mem_wen;
  logic        mem_wready = 1'b0;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  wr_ctrl_wbuf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_wr_valid (acc_wr_valid),
    .acc_wr_ready (acc_wr_ready),
    .acc_wr_addr  (acc_wr_addr),
    .acc_wr_data  (acc_wr_data),
    .acc_wr_strb  (acc_wr_strb),
    .acc_req      (acc_req),
    .acc_gnt      (acc_gnt),
    .acc_cmd      (acc_cmd),
    .acc_index    (acc_index),
    .acc_tag      (acc_tag),
    .acc_status   (acc_status),
    .return_tag   (return_tag),
    .return_index (return_index),
    .fetch_req    (fetch_req),
    .fetch_gnt    (fetch_gnt),
    .fetch_cmd    (fetch_cmd),
    .fetch_addr   (fetch_addr),
    .fetch_tag    (fetch_tag),
    .fetch_done   (fetch_done),
    .mem_wen      (mem_wen),
    .mem_wready   (mem_wready),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_wr_cnt = 0;
  int lookup_cnt = 0;
  logic [6:0]  wlog_addr[$];
  logic [31:0] wlog_data[$];
  logic [3:0]  wlog_strb[$];

  always @(posedge clk) begin
    if (rst_n && mem_wen && mem_wready) begin
      mem_wr_cnt++;
      wlog_addr.push_back(mem_waddr);
      wlog_data.push_back(mem_wdata);
      wlog_strb.push_back(mem_wstrb);
    end
    if (rst_n && acc_req && acc_gnt && acc_cmd == 2'b00) lookup_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output bit ok);
    ok = 1'b0;
    acc_wr_valid = 1'b1;
    acc_wr_addr  = a;
    acc_wr_data  = d;
    acc_wr_strb  = s;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (acc_wr_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    acc_wr_valid = 1'b0;
  endtask

  task automatic acc_grant(input logic [2:0] st, input logic [1:0] tg, input logic [31:0] idx);
    acc_gnt      = 1'b1;
    acc_status   = st;
    return_tag   = tg;
    return_index = idx;
    step();
    acc_gnt      = 1'b0;
    acc_status   = '0;
    return_tag   = '0;
    return_index = '0;
  endtask

  // Answers every lookup with a hit on tag tg and accepts every RAM write until quiet.
  task automatic drain(input logic [1:0] tg, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      acc_gnt    = acc_req;
      acc_status = 3'b001;
      return_tag = tg;
      mem_wready = mem_wen;
      if (!acc_req && !mem_wen && !fetch_req) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    acc_gnt    = 1'b0;
    acc_status = '0;
    return_tag = '0;
    mem_wready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({acc_wr_ready, acc_req, fetch_req, mem_wen} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 1000", {acc_wr_ready, acc_req, fetch_req, mem_wen});
    end
    n_checks++;
    if ({acc_index, fetch_addr, mem_waddr, acc_cmd, fetch_cmd} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h expected 0", acc_index, fetch_addr, mem_waddr);
    end
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({acc_wr_ready, acc_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 10", {acc_wr_ready, acc_req});
    end
  endtask

  task automatic test_hit();
    bit ok;
    int base;
    base = mem_wr_cnt;
    push(32'h104, 32'hDEADBEEF, 4'hF, ok);
    n_checks++;
    if (acc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_idle_cycle: acc_req got %b expected 0", acc_req);
    end
    step();
    n_checks++;
    if ({acc_req, acc_cmd, acc_index} !== {1'b1, 2'b00, 32'h100}) begin
      n_fail++;
      $display("FAIL hit_lookup: got %b %b %h expected 1 00 00000100", acc_req, acc_cmd, acc_index);
    end
    acc_grant(3'b001, 2'd2, '0);
    n_checks++;
    if ({mem_wen, mem_waddr, mem_wdata, mem_wstrb} !== {1'b1, 7'h41, 32'hDEADBEEF, 4'hF}) begin
      n_fail++;
      $display("FAIL hit_memwr: got %b %h %h %h expected 1 41 deadbeef f",
               mem_wen, mem_waddr, mem_wdata, mem_wstrb);
    end
    mem_wready = 1'b1;
    step();
    mem_wready = 1'b0;
    n_checks++;
    if ({acc_req, acc_cmd, acc_tag} !== {1'b1, 2'b11, 2'd2}) begin
      n_fail++;
      $display("FAIL hit_update: got %b %b %0d expected 1 11 2", acc_req, acc_cmd, acc_tag);
    end
    acc_grant(3'b000, 2'd0, '0);
    n_checks++;
    if ({acc_req, acc_wr_ready, mem_wen} !== 3'b010 || mem_wr_cnt - base != 1) begin
      n_fail++;
      $display("FAIL hit_done: got %b writes %0d expected 010 writes 1",
               {acc_req, acc_wr_ready, mem_wen}, mem_wr_cnt - base);
    end
  endtask

  task automatic test_dirty_miss();
    bit ok;
    int base;
    base = mem_wr_cnt;
    push(32'h100, 32'hA5A5A5A5, 4'hF, ok);
    step();
    acc_grant(3'b010, 2'd0, '0);
    n_checks++;
    if ({acc_req, acc_cmd} !== 3'b110) begin
      n_fail++;
      $display("FAIL dm_alloc: got %b %b expected 1 10", acc_req, acc_cmd);
    end
    acc_grant(3'b010, 2'd1, 32'h300);
    n_checks++;
    if ({fetch_req, fetch_cmd, fetch_addr, fetch_tag} !== {1'b1, 2'b00, 32'h300, 2'd1}) begin
      n_fail++;
      $display("FAIL dm_wb_req: got %b %b %h %0d expected 1 00 00000300 1",
               fetch_req, fetch_cmd, fetch_addr, fetch_tag);
    end
    fetch_done = 1'b1;
    step();
    fetch_done = 1'b0;
    n_checks++;
    if ({fetch_req, fetch_cmd} !== 3'b100) begin
      n_fail++;
      $display("FAIL dm_done_ignored: got %b %b expected 1 00", fetch_req, fetch_cmd);
    end
    fetch_gnt = 1'b1;
    step();
    fetch_gnt = 1'b0;
    n_checks++;
    if (fetch_req !== 1'b0) begin
      n_fail++;
      $display("FAIL dm_wb_wait: fetch_req got %b expected 0", fetch_req);
    end
    step();
    fetch_done = 1'b1;
    step();
    fetch_done = 1'b0;
    n_checks++;
    if ({fetch_req, fetch_cmd, fetch_addr, fetch_tag} !== {1'b1, 2'b01, 32'h100, 2'd1}) begin
      n_fail++;
      $display("FAIL dm_rf_req: got %b %b %h %0d expected 1 01 00000100 1",
               fetch_req, fetch_cmd, fetch_addr, fetch_tag);
    end
    fetch_gnt = 1'b1;
    step();
    fetch_gnt = 1'b0;
    fetch_done = 1'b1;
    step();
    fetch_done = 1'b0;
    n_checks++;
    if ({mem_wen, mem_waddr, mem_wdata} !== {1'b1, 7'h20, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL dm_memwr: got %b %h %h expected 1 20 a5a5a5a5", mem_wen, mem_waddr, mem_wdata);
    end
    mem_wready = 1'b1;
    step();
    mem_wready = 1'b0;
    n_checks++;
    if ({acc_req, acc_cmd, acc_tag} !== {1'b1, 2'b11, 2'd1}) begin
      n_fail++;
      $display("FAIL dm_update: got %b %b %0d expected 1 11 1", acc_req, acc_cmd, acc_tag);
    end
    acc_grant(3'b000, 2'd0, '0);
    n_checks++;
    if (acc_req !== 1'b0 || mem_wr_cnt - base != 1) begin
      n_fail++;
      $display("FAIL dm_done: acc_req %b writes %0d expected 0 writes 1", acc_req, mem_wr_cnt - base);
    end
  endtask

  task automatic test_full();
    bit ok;
    int base;
    base = mem_wr_cnt;
    wlog_addr.delete();
    wlog_data.delete();
    wlog_strb.delete();
    for (int i = 1; i <= 4; i++) push(32'(i * 16), 32'(i), 4'hF, ok);
    n_checks++;
    if (acc_wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b expected 0", acc_wr_ready);
    end
    acc_wr_valid = 1'b1;
    acc_wr_addr  = 32'h50;
    acc_wr_data  = 32'd5;
    acc_wr_strb  = 4'hF;
    step();
    step();
    n_checks++;
    if (acc_wr_ready !== 1'b0 || acc_req !== 1'b1) begin
      n_fail++;
      $display("FAIL full_stall: ready %b acc_req %b expected 0 1", acc_wr_ready, acc_req);
    end
    acc_grant(3'b001, 2'd0, '0);
    mem_wready = 1'b1;
    #1;
    n_checks++;
    if ({mem_wen, acc_wr_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_no_passthru: got %b expected 10", {mem_wen, acc_wr_ready});
    end
    step();
    mem_wready = 1'b0;
    n_checks++;
    if (acc_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_after_pop: ready got %b expected 1", acc_wr_ready);
    end
    step();
    acc_wr_valid = 1'b0;
    drain(2'd0, ok);
    n_checks++;
    if (!ok || mem_wr_cnt - base != 5 || wlog_addr.size() != 5) begin
      n_fail++;
      $display("FAIL full_drain: done %0d writes %0d expected 1 writes 5", ok, mem_wr_cnt - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if ({wlog_addr[i], wlog_data[i]} !== {7'(4 * (i + 1)), 32'(i + 1)}) begin
          n_fail++;
          $display("FAIL full_order[%0d]: got %h %h expected %h %h", i, wlog_addr[i], wlog_data[i],
                   7'(4 * (i + 1)), 32'(i + 1));
        end
      end
    end
  endtask

  task automatic test_busy();
    bit ok;
    int base_w;
    int base_l;
    base_w = mem_wr_cnt;
    base_l = lookup_cnt;
    push(32'h180, 32'h0BADF00D, 4'hF, ok);
    step();
    for (int i = 0; i < 3; i++) begin
      acc_grant(3'b100, 2'd0, '0);
      n_checks++;
      if ({acc_req, acc_cmd} !== 3'b100) begin
        n_fail++;
        $display("FAIL busy_reissue[%0d]: got %b %b expected 1 00", i, acc_req, acc_cmd);
      end
    end
    acc_grant(3'b001, 2'd3, '0);
    n_checks++;
    if ({mem_wen, mem_waddr} !== {1'b1, 7'h60}) begin
      n_fail++;
      $display("FAIL busy_memwr: got %b %h expected 1 60", mem_wen, mem_waddr);
    end
    drain(2'd3, ok);
    n_checks++;
    if (!ok || lookup_cnt - base_l != 4 || mem_wr_cnt - base_w != 1) begin
      n_fail++;
      $display("FAIL busy_counts: lookups %0d writes %0d expected 4 1",
               lookup_cnt - base_l, mem_wr_cnt - base_w);
    end
  endtask

  task automatic test_merge();
    bit ok;
    int base;
    base = mem_wr_cnt;
    wlog_addr.delete();
    wlog_data.delete();
    wlog_strb.delete();
    push(32'h100, 32'h0, 4'hF, ok);
    push(32'h200, 32'h00001111, 4'h3, ok);
    push(32'h200, 32'h22220000, 4'hC, ok);
    drain(2'd0, ok);
`ifdef WR_CTRL_MERGE_EN
    n_checks++;
    if (!ok || mem_wr_cnt - base != 2 || wlog_data.size() != 2) begin
      n_fail++;
      $display("FAIL merge_count: writes %0d expected 2", mem_wr_cnt - base);
    end else begin
      n_checks++;
      if ({wlog_data[1], wlog_strb[1]} !== {32'h22221111, 4'hF}) begin
        n_fail++;
        $display("FAIL merge_data: got %h %h expected 22221111 f", wlog_data[1], wlog_strb[1]);
      end
    end
`else
    n_checks++;
    if (!ok || mem_wr_cnt - base != 3 || wlog_data.size() != 3) begin
      n_fail++;
      $display("FAIL nomerge_count: writes %0d expected 3", mem_wr_cnt - base);
    end else begin
      n_checks++;
      if ({wlog_data[1], wlog_strb[1], wlog_data[2], wlog_strb[2]} !==
          {32'h00001111, 4'h3, 32'h22220000, 4'hC}) begin
        n_fail++;
        $display("FAIL nomerge_data: got %h/%h %h/%h expected 00001111/3 22220000/c",
                 wlog_data[1], wlog_strb[1], wlog_data[2], wlog_strb[2]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    push(32'h100, 32'h12345678, 4'hF, ok);
    step();
    acc_grant(3'b000, 2'd0, '0);
    acc_grant(3'b000, 2'd2, 32'h500);
    n_checks++;
    if ({fetch_req, fetch_cmd, fetch_addr, fetch_tag} !== {1'b1, 2'b01, 32'h100, 2'd2}) begin
      n_fail++;
      $display("FAIL rm_rf_req: got %b %b %h %0d expected 1 01 00000100 2",
               fetch_req, fetch_cmd, fetch_addr, fetch_tag);
    end
    fetch_gnt = 1'b1;
    step();
    fetch_gnt = 1'b0;
    push(32'h140, 32'h9, 4'hF, ok);
    base = mem_wr_cnt;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fetch_req, acc_wr_ready, acc_req, mem_wen, fetch_tag} !== 6'b010000) begin
      n_fail++;
      $display("FAIL rm_in_reset: got %b expected 010000",
               {fetch_req, acc_wr_ready, acc_req, mem_wen, fetch_tag});
    end
    step();
    rst_n = 1'b1;
    fetch_done = 1'b1;
    step();
    fetch_done = 1'b0;
    drain(2'd0, ok);
    n_checks++;
    if (!ok || mem_wr_cnt != base || acc_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_discard: writes %0d ready %b expected 0 1", mem_wr_cnt - base, acc_wr_ready);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_hit();
    test_dirty_miss();
    test_full();
    test_busy();
    test_merge();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
